uart_irq_arbiter: RTL and testbench

Interrupt sequencer that sits between the UART event/IRQ generator and the CPU interrupt line. It takes the per-event IRQ bus, picks one pending source by fixed or round-robin priority, and presents it as a single interrupt with a vector ID. It runs an ack / end-of-interrupt handshake, then issues a one-cycle clear pulse back to the generator's event-disable inputs. A short hold-off lets the generator's pipeline drain before the next arbitration.

---
 rtl/uart_irq_arbiter_if.sv | 23 ++
 rtl/uart_irq_arbiter.sv | 96 +++++++++
 tb/tb_uart_irq_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_irq_arbiter_if.sv
// uart_irq_arbiter_if: IRQ bus, CPU handshake and arbiter outputs bundled for uart_irq_arbiter
interface uart_irq_arbiter_if #(
  parameter int EVENTS_NUM = 32,
  parameter int ID_W       = $clog2(EVENTS_NUM)
);
  logic [EVENTS_NUM-1:0] i_irq_bus;
  logic                  i_rr_mode;
  logic                  i_irq_ack;
  logic                  i_eoi;
  logic                  o_irq;
  logic [ID_W-1:0]       o_irq_id;
  logic [EVENTS_NUM-1:0] o_events_clear;
  logic                  o_busy;
  logic                  o_timeout;
  modport master (
    output i_irq_bus, i_rr_mode, i_irq_ack, i_eoi,
    input  o_irq, o_irq_id, o_events_clear, o_busy, o_timeout
  );
  modport slave (
    input  i_irq_bus, i_rr_mode, i_irq_ack, i_eoi,
    output o_irq, o_irq_id, o_events_clear, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_irq_arbiter.sv
// uart_irq_arbiter: fixed/round-robin IRQ sequencer with ack/EOI handshake, clear pulse and hold-off; UART_IRQ_ARB_TIMEOUT_EN adds the ack watchdog
module uart_irq_arbiter #(
  parameter int EVENTS_NUM     = 32,
  parameter int ID_W           = $clog2(EVENTS_NUM),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  uart_irq_arbiter_if.slave       bus_if
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PEND  = 3'd1;
  localparam logic [2:0] S_SERV  = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [ID_W:0] N_EV = (ID_W+1)'(EVENTS_NUM);
  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic                  r_irq;
  logic                  r_busy;
  logic                  r_timeout;
  logic [ID_W-1:0]       r_irq_id;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [EVENTS_NUM-1:0] r_clear;
  logic [1:0]            r_hold_cnt;
  logic [ID_W-1:0]       w_base;
  logic [ID_W-1:0]       w_win;
  logic [ID_W:0]         w_sum;
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_rr_next;
  logic                  w_to_hit;
`ifdef UART_IRQ_ARB_TIMEOUT_EN
  logic [15:0]           r_to_cnt;
  assign w_to_hit = r_to_cnt == 16'(TIMEOUT_CYCLES - 1);
  // PEND-cycle counter, zero whenever not pending so it restarts on every PEND entry
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) r_to_cnt <= '0;
    else         r_to_cnt <= r_state == S_PEND ? r_to_cnt + 16'd1 : '0;
`else
  assign w_to_hit = TIMEOUT_CYCLES < 1;
`endif
  assign w_rr_next = r_irq_id == ID_W'(EVENTS_NUM - 1) ? '0 : r_irq_id + ID_W'(1);
  // winner: first pending source scanning upward from the base, wrapping; last hit in a descending scan is the nearest
  always_comb begin
    w_base = bus_if.i_rr_mode ? r_rr_ptr : '0;
    w_win  = '0;
    w_sum  = '0;
    w_idx  = '0;
    for (int k = EVENTS_NUM - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_base} + (ID_W+1)'(k);
      w_sum = w_sum >= N_EV ? w_sum - N_EV : w_sum;
      w_idx = w_sum[ID_W-1:0];
      w_win = bus_if.i_irq_bus[w_idx] ? w_idx : w_win;
    end
  end
  // next state: in PEND ack beats a dropped source, which beats the watchdog
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = |bus_if.i_irq_bus ? S_PEND : S_IDLE;
      S_PEND:  w_next = bus_if.i_irq_ack ? S_SERV :
                        !bus_if.i_irq_bus[r_irq_id] ? S_IDLE :
                        w_to_hit ? S_CLEAR : S_PEND;
      S_SERV:  w_next = bus_if.i_eoi ? S_CLEAR : S_SERV;
      S_CLEAR: w_next = S_HOLD;
      S_HOLD:  w_next = r_hold_cnt == 2'd1 ? S_IDLE : S_HOLD;
      default: w_next = S_IDLE;
    endcase
  end
  // state and all outputs registered from the next state so they change right after the deciding edge
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      r_state    <= S_IDLE;
      r_irq      <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_irq_id   <= '0;
      r_rr_ptr   <= '0;
      r_clear    <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_irq      <= w_next == S_PEND;
      r_busy     <= w_next != S_IDLE;
      r_clear    <= w_next == S_CLEAR ? EVENTS_NUM'(1) << r_irq_id : '0;
      r_hold_cnt <= r_state == S_HOLD ? r_hold_cnt + 2'd1 : '0;
      r_timeout  <= r_timeout | (r_state == S_PEND && w_next == S_CLEAR);
      if (r_state == S_IDLE && w_next == S_PEND) r_irq_id <= w_win;
      if (r_state == S_CLEAR) r_rr_ptr <= w_rr_next;
    end
  assign bus_if.o_irq          = r_irq;
  assign bus_if.o_irq_id       = r_irq_id;
  assign bus_if.o_events_clear = r_clear;
  assign bus_if.o_busy         = r_busy;
  assign bus_if.o_timeout      = r_timeout;
endmodule

// File: tb/tb_uart_irq_arbiter.sv
// tb_uart_irq_arbiter: directed checks of priority, round-robin wrap, withdraw, stray handshakes, reset and watchdog
module tb_uart_irq_arbiter;
  logic i_clk = 1'b0;
  logic i_nrst = 1'b0;
  int n_tot = 0;
  int n_bad = 0;
  uart_irq_arbiter_if #(.EVENTS_NUM(32)) bus_if();
  uart_irq_arbiter #(.EVENTS_NUM(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .bus_if(bus_if)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask
  task automatic serve(input string tag, input logic [31:0] clr, input logic [31:0] nbus);
    bus_if.i_irq_ack = 1'b1;
    step();
    bus_if.i_irq_ack = 1'b0;
    chk({tag, "_svc_irq"}, 32'(bus_if.o_irq), 0);
    bus_if.i_eoi = 1'b1;
    step();
    bus_if.i_eoi = 1'b0;
    chk({tag, "_clr"}, bus_if.o_events_clear, clr);
    bus_if.i_irq_bus = nbus;
    step();
    chk({tag, "_clr_off"}, bus_if.o_events_clear, 0);
    step(2);
    chk({tag, "_idle"}, 32'(bus_if.o_busy), 0);
  endtask
  initial begin
    bus_if.i_irq_bus = '0;
    bus_if.i_rr_mode = 1'b0;
    bus_if.i_irq_ack = 1'b0;
    bus_if.i_eoi     = 1'b0;
    step(2);
    chk("rst_irq", 32'(bus_if.o_irq), 0);
    chk("rst_id", 32'(bus_if.o_irq_id), 0);
    chk("rst_clr", bus_if.o_events_clear, 0);
    chk("rst_busy", 32'(bus_if.o_busy), 0);
    chk("rst_to", 32'(bus_if.o_timeout), 0);
    i_nrst = 1'b1;
    step();
    bus_if.i_irq_bus = 32'h0000_0090;
    step();
    chk("fix_irq", 32'(bus_if.o_irq), 1);
    chk("fix_id", 32'(bus_if.o_irq_id), 4);
    bus_if.i_irq_ack = 1'b1;
    step();
    bus_if.i_irq_ack = 1'b0;
    chk("fix_ack_irq", 32'(bus_if.o_irq), 0);
    chk("fix_ack_busy", 32'(bus_if.o_busy), 1);
    bus_if.i_eoi = 1'b1;
    step();
    bus_if.i_eoi = 1'b0;
    chk("fix_clr", bus_if.o_events_clear, 32'h10);
    bus_if.i_irq_bus = 32'h0000_0080;
    step();
    chk("fix_hold1_clr", bus_if.o_events_clear, 0);
    chk("fix_hold1_busy", 32'(bus_if.o_busy), 1);
    step();
    chk("fix_hold2_busy", 32'(bus_if.o_busy), 1);
    chk("fix_hold2_irq", 32'(bus_if.o_irq), 0);
    step();
    chk("fix_idle_busy", 32'(bus_if.o_busy), 0);
    chk("fix_idle_id", 32'(bus_if.o_irq_id), 4);
    step();
    chk("fix_next_irq", 32'(bus_if.o_irq), 1);
    chk("fix_next_id", 32'(bus_if.o_irq_id), 7);
    serve("fix7", 32'h80, 32'h0);
    bus_if.i_irq_bus = 32'h0000_0020;
    step();
    chk("rs_id", 32'(bus_if.o_irq_id), 5);
    bus_if.i_irq_ack = 1'b1;
    step();
    bus_if.i_irq_ack = 1'b0;
    chk("rs_svc_busy", 32'(bus_if.o_busy), 1);
    bus_if.i_eoi = 1'b1;
    i_nrst = 1'b0;
    #1;
    chk("rs_irq", 32'(bus_if.o_irq), 0);
    chk("rs_id0", 32'(bus_if.o_irq_id), 0);
    chk("rs_busy", 32'(bus_if.o_busy), 0);
    chk("rs_clr", bus_if.o_events_clear, 0);
    step();
    bus_if.i_eoi = 1'b0;
    bus_if.i_irq_bus = '0;
    i_nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs_noclr", bus_if.o_events_clear, 0);
    end
    bus_if.i_rr_mode = 1'b1;
    bus_if.i_irq_bus = 32'h8000_0001;
    step();
    chk("rr_id0", 32'(bus_if.o_irq_id), 0);
    serve("rr0", 32'h1, 32'h8000_0000);
    step();
    chk("rr_id31", 32'(bus_if.o_irq_id), 31);
    serve("rr31", 32'h8000_0000, 32'h8000_0001);
    step();
    chk("rr_wrap_id", 32'(bus_if.o_irq_id), 0);
    serve("rr0b", 32'h1, 32'h3);
    step();
    chk("rr_ptr1_id", 32'(bus_if.o_irq_id), 1);
    bus_if.i_irq_bus = 32'h1;
    step();
    chk("wd_irq", 32'(bus_if.o_irq), 0);
    chk("wd_busy", 32'(bus_if.o_busy), 0);
    chk("wd_clr", bus_if.o_events_clear, 0);
    bus_if.i_irq_bus = 32'h3;
    step();
    chk("wd_ptr_kept", 32'(bus_if.o_irq_id), 1);
    bus_if.i_irq_ack = 1'b1;
    bus_if.i_irq_bus = 32'h1;
    step();
    chk("wd_ackwin_irq", 32'(bus_if.o_irq), 0);
    chk("wd_ackwin_busy", 32'(bus_if.o_busy), 1);
    step();
    bus_if.i_irq_ack = 1'b0;
    chk("stray_ack_busy", 32'(bus_if.o_busy), 1);
    chk("stray_ack_irq", 32'(bus_if.o_irq), 0);
    chk("stray_ack_clr", bus_if.o_events_clear, 0);
    bus_if.i_eoi = 1'b1;
    step();
    bus_if.i_eoi = 1'b0;
    chk("wd_svc_clr", bus_if.o_events_clear, 32'h2);
    bus_if.i_irq_bus = '0;
    step(3);
    bus_if.i_rr_mode = 1'b0;
    bus_if.i_irq_bus = 32'h4;
    step();
    chk("stray_pend_id", 32'(bus_if.o_irq_id), 2);
    bus_if.i_eoi = 1'b1;
    step();
    bus_if.i_eoi = 1'b0;
    chk("stray_eoi_irq", 32'(bus_if.o_irq), 1);
    chk("stray_eoi_clr", bus_if.o_events_clear, 0);
    bus_if.i_irq_bus = '0;
    step();
    chk("stray_wd_busy", 32'(bus_if.o_busy), 0);
    bus_if.i_irq_bus = 32'h8;
    step();
    chk("to_id", 32'(bus_if.o_irq_id), 3);
`ifdef UART_IRQ_ARB_TIMEOUT_EN
    step(7);
    chk("to_ack8_pend", 32'(bus_if.o_irq), 1);
    bus_if.i_irq_ack = 1'b1;
    step();
    bus_if.i_irq_ack = 1'b0;
    chk("to_ack8_irq", 32'(bus_if.o_irq), 0);
    chk("to_ack8_flag", 32'(bus_if.o_timeout), 0);
    chk("to_ack8_clr", bus_if.o_events_clear, 0);
    bus_if.i_eoi = 1'b1;
    step();
    bus_if.i_eoi = 1'b0;
    step(3);
    step();
    step(7);
    chk("to_c8_irq", 32'(bus_if.o_irq), 1);
    chk("to_c8_flag", 32'(bus_if.o_timeout), 0);
    step();
    chk("to_flag", 32'(bus_if.o_timeout), 1);
    chk("to_irq", 32'(bus_if.o_irq), 0);
    chk("to_clr", bus_if.o_events_clear, 32'h8);
    bus_if.i_irq_bus = '0;
    step(3);
    chk("to_idle", 32'(bus_if.o_busy), 0);
    chk("to_sticky", 32'(bus_if.o_timeout), 1);
`else
    step(20);
    chk("nto_irq", 32'(bus_if.o_irq), 1);
    chk("nto_flag", 32'(bus_if.o_timeout), 0);
    serve("nto", 32'h8, 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
